mux_scan_sequencer: RTL and testbench

//  - Upstream driver and downstream collector for the 16-to-1 channel mux.
//  - Steps mux select s through channels 0..15 and waits a settle time on each before sampling mux output f.
//  - Assembles one 16-bit snapshot per scan and hands it to the consumer over a valid/ready handshake.

---
 rtl/mux_scan_sequencer_pkg.sv | 31 +++
 rtl/mux_scan_settle_cnt.sv | 34 +++
 rtl/mux_scan_sequencer.sv | 158 +++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_sequencer_pkg
// Brief    : Shared state encoding, size defaults and settle-load helper for
//            the 16-to-1 mux scan sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mux_scan_sequencer_pkg;

  localparam int N_CH_DEF  = 16;
  localparam int SEL_W_DEF = 4;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // The settle counter holds "remaining idle cycles minus one" so that the
  // zero flag marks the last SETTLE cycle and SAMPLE follows on the next edge.
  function automatic logic [CNT_W-1:0] settle_load(input int settle);
    if (settle <= 0) begin
      return '0;
    end
    return CNT_W'(settle - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_scan_settle_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_settle_cnt
// Brief    : Loadable saturating down-counter timing the settle interval
//            after each select change.
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan_settle_cnt
  import mux_scan_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_sequencer
// Brief    : Steps the mux select through every channel, waits a settle time,
//            samples the mux output and presents one snapshot per scan over a
//            valid/ready handshake.
// Options  : SCAN_CHANGE_DETECT_EN adds changed/any_change outputs comparing
//            each new snapshot with the last accepted one.
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              f,
  output logic [SEL_W-1:0]  s,
  output logic              busy,
  output logic [0:N_CH-1]   snap,
  output logic              snap_valid,
`ifdef SCAN_CHANGE_DETECT_EN
  output logic [0:N_CH-1]   changed,
  output logic              any_change,
`endif
  input  logic              snap_ready
);

  localparam logic [SEL_W-1:0] c_LAST     = SEL_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] c_LOAD     = settle_load(SETTLE);
  // With no settle time each channel goes straight from select to sample.
  localparam state_e           c_RUN_ST   = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  state_e            state_q;
  logic [SEL_W-1:0]  s_q;
  logic              busy_q;
  logic [0:N_CH-1]   scratch_q;
  logic [0:N_CH-1]   snap_q;
  logic              snap_valid_q;

  logic [0:N_CH-1]   snap_d;
  logic              w_handshake;
  logic              w_begin;
  logic              w_scan_done;
  logic              w_cnt_load;
  logic              w_cnt_zero;

  assign w_handshake = (state_q == ST_HOLD) && snap_valid_q && snap_ready;
  assign w_begin     = start && ((state_q == ST_IDLE) || w_handshake);
  assign w_scan_done = (state_q == ST_SAMPLE) && (s_q == c_LAST);
  assign w_cnt_load  = w_begin || ((state_q == ST_SAMPLE) && (s_q != c_LAST));

  // Completed snapshot: scratch with the bit sampled this cycle merged in.
  always_comb begin
    snap_d      = scratch_q;
    snap_d[s_q] = f;
  end

  mux_scan_settle_cnt u_settle_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (w_cnt_load),
    .load_val (c_LOAD),
    .zero     (w_cnt_zero)
  );

  // Scan FSM with registered select, busy, scratch and snapshot outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      s_q          <= '0;
      busy_q       <= 1'b0;
      scratch_q    <= '0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= c_RUN_ST;
            s_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (w_cnt_zero) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          scratch_q[s_q] <= f;
          if (s_q != c_LAST) begin
            s_q     <= s_q + SEL_W'(1);
            state_q <= c_RUN_ST;
          end else begin
            snap_q       <= snap_d;
            snap_valid_q <= 1'b1;
            s_q          <= '0;
            busy_q       <= 1'b0;
            state_q      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_handshake) begin
            snap_valid_q <= 1'b0;
            if (start) begin
              state_q <= c_RUN_ST;
              s_q     <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s          = s_q;
  assign busy       = busy_q;
  assign snap       = snap_q;
  assign snap_valid = snap_valid_q;

`ifdef SCAN_CHANGE_DETECT_EN
  logic [0:N_CH-1] baseline_q;
  logic [0:N_CH-1] changed_q;
  logic            any_change_q;

  // Compare each new snapshot with the last one the consumer accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baseline_q   <= '0;
      changed_q    <= '0;
      any_change_q <= 1'b0;
    end else begin
      if (w_handshake) begin
        baseline_q <= snap_q;
      end
      if (w_scan_done) begin
        changed_q    <= snap_d ^ baseline_q;
        any_change_q <= |(snap_d ^ baseline_q);
      end
    end
  end

  assign changed    = changed_q;
  assign any_change = any_change_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan_sequencer
// Brief    : Directed and randomized scans of the sequencer against a simple
//            arithmetic model of select timing, latency and snapshot content.
//            Second instance runs with zero settle time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan_sequencer;

  localparam int N      = 16;
  localparam int SETTLE = 1;
  localparam int SCAN_CYC = N * (SETTLE + 1);

  logic        clk = 1'b0;
  logic        reset;
  logic        start, snap_ready;
  logic [0:15] w;
  logic [3:0]  s;
  logic        busy, snap_valid;
  logic [0:15] snap;
  logic        f;

  logic        start0, snap_ready0;
  logic [0:15] w0;
  logic [3:0]  s0;
  logic        busy0, snap_valid0;
  logic [0:15] snap0;
  logic        f0;

`ifdef SCAN_CHANGE_DETECT_EN
  logic [0:15] changed, changed0;
  logic        any_change, any_change0;
  logic [15:0] bl;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Real 16-to-1 muxes driving the sampled inputs.
  assign f  = w[s];
  assign f0 = w0[s0];

  mux_scan_sequencer #(.N_CH(16), .SEL_W(4), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .start(start), .f(f), .s(s), .busy(busy),
    .snap(snap), .snap_valid(snap_valid),
`ifdef SCAN_CHANGE_DETECT_EN
    .changed(changed), .any_change(any_change),
`endif
    .snap_ready(snap_ready)
  );

  mux_scan_sequencer #(.N_CH(16), .SEL_W(4), .SETTLE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .f(f0), .s(s0), .busy(busy0),
    .snap(snap0), .snap_valid(snap_valid0),
`ifdef SCAN_CHANGE_DETECT_EN
    .changed(changed0), .any_change(any_change0),
`endif
    .snap_ready(snap_ready0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the edge that accepted the start; expects select
  // to dwell SETTLE+1 cycles per channel and the snapshot after N*(SETTLE+1).
  task automatic scan_body(input logic [15:0] wv);
    for (int k = 0; k < SCAN_CYC; k++) begin
      check("busy_in_scan", busy, 1);
      check("s_sequence", s, (k / (SETTLE + 1)) % N);
      check("valid_low_in_scan", snap_valid, 0);
      tick();
    end
    check("busy_done", busy, 0);
    check("valid_done", snap_valid, 1);
    check("snap_value", snap, wv);
    check("s_wrapped", s, 0);
`ifdef SCAN_CHANGE_DETECT_EN
    check("changed", changed, wv ^ bl);
    check("any_change", any_change, |(wv ^ bl));
`endif
  endtask

  task automatic do_scan(input logic [15:0] wv, input logic hold_start);
    w = wv;
    start = 1'b1;
    tick();
    start = hold_start;
    scan_body(wv);
    start = 1'b0;
  endtask

  task automatic accept();
`ifdef SCAN_CHANGE_DETECT_EN
    bl = snap;
`endif
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
    check("valid_after_accept", snap_valid, 0);
    check("idle_after_accept", busy, 0);
  endtask

  initial begin
    logic [15:0] held, wv;
    int n;
    reset = 1'b1; start = 1'b0; snap_ready = 1'b0; w = '0;
    start0 = 1'b0; snap_ready0 = 1'b0; w0 = '0;
`ifdef SCAN_CHANGE_DETECT_EN
    bl = '0;
`endif
    tick(); tick();
    check("rst_s", s, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", snap_valid, 0);
    check("rst_snap", snap, 0);
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Full scan of a known pattern.
    do_scan(16'hA5C3, 1'b0);

    // Backpressure: start without ready is ignored and snap holds.
    held = snap;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", snap_valid, 1);
      check("bp_snap", snap, held);
      check("bp_busy", busy, 0);
      check("bp_s", s, 0);
    end
    wv = 16'($urandom);
    w = wv;
`ifdef SCAN_CHANGE_DETECT_EN
    bl = snap;
`endif
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
    start = 1'b0;
    check("hs_valid_drop", snap_valid, 0);
    scan_body(wv);
    accept();

    // Abort mid-scan at channel 7 with an asynchronous reset.
    w = 16'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (s !== 4'd7 && n < 40) begin
      tick();
      n++;
    end
    check("abort_reach_s7", s, 7);
    #2 reset = 1'b1;
    #1;
    check("abort_s", s, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", snap_valid, 0);
    check("abort_snap", snap, 0);
    tick();
    reset = 1'b0;
`ifdef SCAN_CHANGE_DETECT_EN
    bl = '0;
`endif
    tick();
    check("abort_idle_busy", busy, 0);
    do_scan(16'hFFFF, 1'b0);
    accept();

    // Randomized scans; start sometimes held high through the scan.
    for (int r = 0; r < 5; r++) begin
      do_scan(16'($urandom), 1'($urandom));
      accept();
    end

`ifdef SCAN_CHANGE_DETECT_EN
    do_scan(16'h00FF, 1'b0);
    accept();
    do_scan(16'h0F0F, 1'b0);
    check("cd_changed", changed, 16'h0FF0);
    check("cd_any", any_change, 1);
    accept();
    do_scan(16'h0F0F, 1'b0);
    check("cd_same_changed", changed, 0);
    check("cd_same_any", any_change, 0);
    accept();
`endif

    // Zero settle time: snapshot exactly N cycles after the start edge.
    for (int r = 0; r < 2; r++) begin
      wv = 16'($urandom);
      w0 = wv;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      n = 0;
      while (!snap_valid0 && n < 40) begin
        tick();
        n++;
      end
      check("s0_latency", n, N);
      check("s0_snap", snap0, wv);
      snap_ready0 = 1'b1;
      tick();
      snap_ready0 = 1'b0;
      check("s0_accept", snap_valid0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
